// File: rtl/crossing_pkg.sv
// Shared types and default phase durations for the crossing scheduler.
package crossing_pkg;

  typedef enum logic [2:0] {
    VGREEN,
    VYELLOW,
    ALLRED,
    WALK,
    PCLEAR
  } phase_t;

  localparam int unsigned DefNReq  = 4;
  localparam int unsigned DefTw    = 25;
  localparam int unsigned DefTVmin = 8;
  localparam int unsigned DefTYel  = 3;
  localparam int unsigned DefTClr  = 2;
  localparam int unsigned DefTWalk = 5;
  localparam int unsigned DefTPclr = 4;

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin picker: first set bit of pending at or after ptr+1, wrapping.
module rr_arbiter #(
  parameter int unsigned N_REQ = 4,
  localparam int unsigned IW = $clog2(N_REQ)
) (
  input  logic [N_REQ-1:0] pending,
  input  logic [IW-1:0]    ptr,
  output logic [IW-1:0]    gnt_idx,
  output logic             valid
);

  always_comb begin
    int unsigned idx;
    idx     = 0;
    gnt_idx = '0;
    valid   = 1'b0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = (32'(ptr) + off) % N_REQ;
      if (!valid && pending[idx]) begin
        valid   = 1'b1;
        gnt_idx = IW'(idx);
      end
    end
  end

endmodule

// File: rtl/crossing_scheduler.sv
// Round-robin pedestrian crossing scheduler driving one vehicle head and N_REQ walk lamps.
module crossing_scheduler
  import crossing_pkg::*;
#(
  parameter int unsigned N_REQ  = DefNReq,
  parameter int unsigned TW     = DefTw,
  parameter int unsigned T_VMIN = DefTVmin,
  parameter int unsigned T_YEL  = DefTYel,
  parameter int unsigned T_CLR  = DefTClr,
  parameter int unsigned T_WALK = DefTWalk,
  parameter int unsigned T_PCLR = DefTPclr
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic [N_REQ-1:0] req,
  output logic             veh_g,
  output logic             veh_y,
  output logic             veh_r,
  output logic [N_REQ-1:0] ped_walk,
  output logic [N_REQ-1:0] ped_flash,
  output logic [N_REQ-1:0] ack,
  output logic [N_REQ-1:0] pending
);

  localparam int unsigned IW = $clog2(N_REQ);

  function automatic logic [TW-1:0] dur_load(input int unsigned d);
    return TW'(d - 1);
  endfunction

  phase_t           state_q, state_d;
  logic [TW-1:0]    tmr_q, tmr_d;
  logic [N_REQ-1:0] pending_q, pending_d;
  logic [IW-1:0]    gnt_q, ptr_q;
  logic [IW-1:0]    arb_idx;
  logic             arb_valid;
  logic             expired;
  logic             grant;
  logic [N_REQ-1:0] gnt_oh;
  logic [N_REQ-1:0] walk_mask;

  assign expired = (tmr_q == '0);
  assign gnt_oh  = N_REQ'(1) << gnt_q;

  rr_arbiter #(
    .N_REQ(N_REQ)
  ) u_arb (
    .pending(pending_q),
    .ptr    (ptr_q),
    .gnt_idx(arb_idx),
    .valid  (arb_valid)
  );

  always_comb begin
    state_d = state_q;
    tmr_d   = expired ? '0 : tmr_q - TW'(1);
    grant   = 1'b0;
    case (state_q)
      VGREEN: begin
        if (expired && |pending_q) begin
          state_d = VYELLOW;
          tmr_d   = dur_load(T_YEL);
        end
      end
      VYELLOW: begin
        if (expired) begin
          state_d = ALLRED;
          tmr_d   = dur_load(T_CLR);
        end
      end
      ALLRED: begin
        if (expired) begin
          state_d = WALK;
          tmr_d   = dur_load(T_WALK);
          grant   = arb_valid;
        end
      end
      WALK: begin
        if (expired) begin
          state_d = PCLEAR;
          tmr_d   = dur_load(T_PCLR);
        end
      end
      PCLEAR: begin
        if (expired) begin
          state_d = VGREEN;
          tmr_d   = dur_load(T_VMIN);
        end
      end
      default: begin
        state_d = VGREEN;
        tmr_d   = dur_load(T_VMIN);
      end
    endcase
  end

  // The granted button is masked while its crossing is being served; the grant clear wins.
  always_comb begin
    walk_mask = (state_q == WALK || state_q == PCLEAR) ? gnt_oh : '0;
    pending_d = pending_q | (req & ~walk_mask);
    if (grant) begin
      pending_d[arb_idx] = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= VGREEN;
      tmr_q     <= dur_load(T_VMIN);
      pending_q <= '0;
      gnt_q     <= '0;
      ptr_q     <= IW'(N_REQ - 1);
    end else begin
      state_q   <= state_d;
      tmr_q     <= tmr_d;
      pending_q <= pending_d;
      if (grant) begin
        gnt_q <= arb_idx;
        ptr_q <= arb_idx;
      end
    end
  end

  assign veh_g     = (state_q == VGREEN);
  assign veh_y     = (state_q == VYELLOW);
  assign veh_r     = (state_q == ALLRED) || (state_q == WALK) || (state_q == PCLEAR);
  assign ped_walk  = (state_q == WALK) ? gnt_oh : '0;
  assign ped_flash = (state_q == PCLEAR) ? gnt_oh : '0;
  assign ack       = (state_q == WALK && tmr_q == dur_load(T_WALK)) ? gnt_oh : '0;
  assign pending   = pending_q;

endmodule

// File: tb/tb_crossing_scheduler.sv
// Self-checking bench for crossing_scheduler: directed scenarios plus a random run vs a phase model.
module tb_crossing_scheduler;

  localparam int N = 4;

  logic         clk = 1'b0;
  logic         reset_n = 1'b0;
  logic [N-1:0] req = '0;
  logic         veh_g, veh_y, veh_r;
  logic [N-1:0] ped_walk, ped_flash, ack, pending;

  int errors = 0;
  int checks = 0;
  int cyc = 0;

  // Reference model: phase index 0..4 (green, yellow, allred, walk, clear) and elapsed cycles.
  int           dur_tab[5] = '{8, 3, 2, 5, 4};
  int           m_phase, m_el, m_gnt, m_ptr;
  logic [N-1:0] m_pend;

  crossing_scheduler dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .req      (req),
    .veh_g    (veh_g),
    .veh_y    (veh_y),
    .veh_r    (veh_r),
    .ped_walk (ped_walk),
    .ped_flash(ped_flash),
    .ack      (ack),
    .pending  (pending)
  );

  always #5 clk = ~clk;

  task automatic model_reset();
    m_phase = 0;
    m_el    = 0;
    m_pend  = '0;
    m_gnt   = 0;
    m_ptr   = N - 1;
  endtask

  task automatic model_update(input logic [N-1:0] r);
    logic [N-1:0] old_p;
    int win;
    old_p = m_pend;
    win   = -1;
    for (int i = 0; i < N; i++) begin
      if (r[i] && !((m_phase == 3 || m_phase == 4) && i == m_gnt)) m_pend[i] = 1'b1;
    end
    if (m_phase == 0) begin
      if (m_el >= dur_tab[0] - 1 && old_p != '0) begin
        m_phase = 1;
        m_el    = 0;
      end else begin
        m_el++;
      end
    end else if (m_el == dur_tab[m_phase] - 1) begin
      if (m_phase == 2) begin
        for (int k = 1; k <= N; k++) begin
          if (win < 0 && old_p[(m_ptr + k) % N]) win = (m_ptr + k) % N;
        end
        if (win >= 0) begin
          m_pend[win] = 1'b0;
          m_gnt       = win;
          m_ptr       = win;
        end
      end
      m_phase = (m_phase + 1) % 5;
      m_el    = 0;
    end else begin
      m_el++;
    end
  endtask

  function automatic logic [3*N+2:0] model_out();
    logic [N-1:0] oh;
    oh = '0;
    oh[m_gnt] = 1'b1;
    return {m_phase == 0, m_phase == 1, m_phase >= 2,
            (m_phase == 3) ? oh : 4'b0, (m_phase == 4) ? oh : 4'b0,
            (m_phase == 3 && m_el == 0) ? oh : 4'b0};
  endfunction

  // Apply r for the current cycle, advance one clock, land on the next falling edge.
  task automatic tick(input logic [N-1:0] r);
    req = r;
    model_update(r);
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req     = '0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 1'b0;
    req = '0;
    #1;
    checks++;
    if ({veh_g, veh_y, veh_r, ped_walk, ped_flash, ack, pending} !== {3'b100, 16'h0}) begin
      errors++;
      $display("FAIL reset_values got=%b exp=%b",
               {veh_g, veh_y, veh_r, ped_walk, ped_flash, ack, pending}, {3'b100, 16'h0});
    end
    do_reset();
    for (int c = 0; c < 60; c++) begin
      checks++;
      if ({veh_g, veh_y, veh_r, ped_walk, ped_flash, ack} !== {3'b100, 12'h0}) begin
        errors++;
        $display("FAIL idle_green c=%0d got=%b exp=%b", c,
                 {veh_g, veh_y, veh_r, ped_walk, ped_flash, ack}, {3'b100, 12'h0});
      end
      tick('0);
    end
  endtask

  task automatic test_single();
    logic [18:0] exp, got;
    do_reset();
    while (cyc < 20) tick('0);
    tick(4'b0100);
    for (int c = 21; c <= 40; c++) begin
      exp = {(c < 22) || (c >= 36), (c >= 22 && c <= 24), (c >= 25 && c <= 35),
             (c >= 27 && c <= 31) ? 4'b0100 : 4'b0000,
             (c >= 32 && c <= 35) ? 4'b0100 : 4'b0000,
             (c == 27) ? 4'b0100 : 4'b0000,
             (c < 27) ? 4'b0100 : 4'b0000};
      got = {veh_g, veh_y, veh_r, ped_walk, ped_flash, ack, pending};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL single_req c=%0d got=%b exp=%b", c, got, exp);
      end
      tick('0);
    end
  endtask

  task automatic test_min_green();
    do_reset();
    tick('0);
    tick('0);
    tick(4'b0010);
    for (int c = 3; c <= 10; c++) begin
      checks++;
      if ({veh_g, veh_y} !== {c < 8, c >= 8}) begin
        errors++;
        $display("FAIL min_green c=%0d got=%b exp=%b", c, {veh_g, veh_y}, {c < 8, c >= 8});
      end
      tick('0);
    end
  endtask

  task automatic test_simultaneous();
    logic [N-1:0] aq[$];
    int           ac[$];
    do_reset();
    tick(4'b1001);
    for (int c = 1; c <= 60; c++) begin
      if (ack != '0) begin
        aq.push_back(ack);
        ac.push_back(cyc);
      end
      tick('0);
    end
    checks++;
    if (aq.size() != 2) begin
      errors++;
      $display("FAIL simul_count got=%0d exp=2", aq.size());
    end else begin
      checks++;
      if ({aq[0], aq[1]} !== 8'b0001_1000) begin
        errors++;
        $display("FAIL simul_order got=%b,%b exp=0001,1000", aq[0], aq[1]);
      end
      checks++;
      if (ac[0] != 13 || ac[1] != 35) begin
        errors++;
        $display("FAIL simul_timing got=%0d,%0d exp=13,35", ac[0], ac[1]);
      end
    end
  endtask

  // Continues from test_simultaneous: last grant was index 3.
  task automatic test_rr_order();
    logic [N-1:0] aq[$];
    tick(4'b1010);
    for (int c = 0; c < 60; c++) begin
      if (ack != '0) aq.push_back(ack);
      tick('0);
    end
    checks++;
    if (aq.size() != 2 || aq[0] !== 4'b0010 || aq[1] !== 4'b1000) begin
      errors++;
      $display("FAIL rr_order got_n=%0d first=%b second=%b exp=0010,1000", aq.size(),
               (aq.size() > 0) ? aq[0] : 4'bx, (aq.size() > 1) ? aq[1] : 4'bx);
    end
  endtask

  task automatic test_hold();
    int n, nack, nack2;
    logic seen_walk;
    do_reset();
    n = 0;
    nack = 0;
    nack2 = 0;
    seen_walk = 1'b0;
    while (!(seen_walk && veh_g) && n < 100) begin
      if (ped_walk == 4'b0100) seen_walk = 1'b1;
      if (ack != '0) nack++;
      tick(4'b0100);
      n++;
    end
    checks++;
    if (n >= 100) begin
      errors++;
      $display("FAIL hold_timeout got=%0d cycles exp=<100", n);
    end
    for (int c = 0; c < 30; c++) begin
      if (ack != '0) nack2++;
      tick('0);
    end
    checks++;
    if (nack != 1 || nack2 != 0 || pending !== 4'b0000) begin
      errors++;
      $display("FAIL hold_no_regrant got acks=%0d,%0d pending=%b exp=1,0,0000",
               nack, nack2, pending);
    end
    tick(4'b0100);
    checks++;
    if (pending !== 4'b0100) begin
      errors++;
      $display("FAIL hold_relatch got=%b exp=0100", pending);
    end
  endtask

  task automatic test_reset_mid();
    int n;
    logic [N-1:0] first;
    do_reset();
    tick(4'b0100);
    n = 0;
    while (ped_walk == '0 && n < 60) begin
      tick('0);
      n++;
    end
    tick(4'b1000);
    checks++;
    if (ped_walk !== 4'b0100 || pending !== 4'b1000) begin
      errors++;
      $display("FAIL mid_setup got walk=%b pending=%b exp=0100,1000", ped_walk, pending);
    end
    reset_n = 1'b0;
    #1;
    checks++;
    if ({veh_g, veh_y, veh_r, ped_walk, ped_flash, ack, pending} !== {3'b100, 16'h0}) begin
      errors++;
      $display("FAIL mid_reset got=%b exp=%b",
               {veh_g, veh_y, veh_r, ped_walk, ped_flash, ack, pending}, {3'b100, 16'h0});
    end
    model_reset();
    @(negedge clk);
    reset_n = 1'b1;
    cyc = 0;
    tick(4'b0101);
    first = '0;
    n = 0;
    while (first == '0 && n < 60) begin
      first = ack;
      tick('0);
      n++;
    end
    checks++;
    if (first !== 4'b0001) begin
      errors++;
      $display("FAIL mid_first_grant got=%b exp=0001", first);
    end
  endtask

  task automatic test_random();
    logic [N-1:0] r;
    logic [18:0]  got, exp;
    do_reset();
    for (int c = 0; c < 600; c++) begin
      got = {veh_g, veh_y, veh_r, ped_walk, ped_flash, ack, pending};
      exp = {model_out(), m_pend};
      checks++;
      if (got !== exp) begin
        errors++;
        $display("FAIL random c=%0d got=%b exp=%b", c, got, exp);
      end
      for (int i = 0; i < N; i++) r[i] = ($urandom_range(0, 9) == 0);
      tick(r);
    end
  endtask

  initial begin
    model_reset();
    test_reset();
    test_single();
    test_min_green();
    test_simultaneous();
    test_rr_order();
    test_hold();
    test_reset_mid();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
